fetch_queue: RTL and testbench

- Decoupling buffer between the program-counter/instruction-memory fetch pair and the IF/ID decode stage.
- Each cycle it captures the fetched instruction and its PC+4 into a small circular queue.
- It presents the oldest entry to decode with a valid/ready handshake.
- It drives the PC's enable so fetch stalls only when the queue is full and decode is not consuming.
- Flush discards all queued and in-flight fetches on branch/jump redirect.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/fetch_queue_ram.sv | 40 ++++
 rtl/fetch_queue.sv | 92 +++++++++
 tb/tb_fetch_queue.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU-wide constants and the fetch queue entry type.
// INSTR_W / ADDR_W : instruction and address widths.
// PC_INCR          : sequential fetch stride.
// NOP_INSTR        : value held in empty storage after reset.
// fq_entry_t       : one queued fetch, the instruction and the address after it.
package cpu_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;

  localparam logic [ADDR_W-1:0]  PC_INCR   = 32'd4;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc_plus4;
  } fq_entry_t;

  localparam fq_entry_t RESET_ENTRY = '{instr: NOP_INSTR, pc_plus4: '0};

endpackage

// File: rtl/fetch_queue_ram.sv
// DEPTH x fq_entry_t register array backing the fetch queue.
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   we         : write enable, captures wr_data at wr_addr on the clock edge
//   wr_addr    : write index
//   wr_data    : entry to store
//   rd_addr    : read index
//   rd_data    : entry at rd_addr, combinational read
module fetch_queue_ram
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [PTR_W-1:0] wr_addr,
  input  fq_entry_t        wr_data,
  input  logic [PTR_W-1:0] rd_addr,
  output fq_entry_t        rd_data
);

  fq_entry_t mem [DEPTH];

  // NOTE: the array is reset because the head outputs are read straight from
  // it and must show zero after reset; that is affordable at this small depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= RESET_ENTRY;
      end
    end else if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fetch_queue.sv
// Decoupling queue between the PC / instruction-memory fetch pair and decode.
// Every fetch that the PC is allowed to make is queued together with its
// PC+4; decode sees the oldest entry through a valid/ready handshake.
// Ports:
//   Clk, Reset_n   : clock (rising edge), asynchronous active-low reset
//   PCResult       : current fetch address
//   Instruction    : instruction-memory data for PCResult (same cycle)
//   Flush          : redirect, drops queued entries and the current fetch
//   PCEn           : PC register enable
//   DecValid       : head entry present
//   DecInstruction : head instruction
//   DecPCPlus4     : head PC+4
//   DecReady       : decode takes the head this cycle
//   Count          : number of valid entries, 0..DEPTH
// DEPTH must be a power of two (>= 2) so pointer arithmetic wraps naturally.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic [ADDR_W-1:0]  PCResult,
  input  logic [INSTR_W-1:0] Instruction,
  input  logic               Flush,
  output logic               PCEn,
  output logic               DecValid,
  output logic [INSTR_W-1:0] DecInstruction,
  output logic [ADDR_W-1:0]  DecPCPlus4,
  input  logic               DecReady,
  output logic [PTR_W:0]     Count
);

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE    = (PTR_W + 1)'(1);

  // Pointers carry one extra wrap bit above the index, so their difference
  // is the occupancy and "full" (same index, different wrap) is distinct
  // from "empty" (identical pointers).
  logic [PTR_W:0] wr_ptr;
  logic [PTR_W:0] rd_ptr;
  logic           full;
  logic           push;
  logic           pop;
  fq_entry_t      wr_entry;
  fq_entry_t      head;

  assign Count    = wr_ptr - rd_ptr;
  assign full     = (Count == FULL_COUNT);
  assign DecValid = (Count != '0);

  // When full, a consuming decode frees the head slot in the same edge, so
  // fetch may proceed; during Flush the PC must load the redirect target.
  assign PCEn = Flush | ~full | DecReady;
  assign push = PCEn & ~Flush;
  assign pop  = DecValid & DecReady & ~Flush;

  assign wr_entry = '{instr: Instruction, pc_plus4: PCResult + PC_INCR};

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (Flush) begin
      // Stale storage is left in place; it is unreachable once rd_ptr == wr_ptr.
      rd_ptr <= wr_ptr;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  fetch_queue_ram #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_ram (
    .clk     (Clk),
    .rst_n   (Reset_n),
    .we      (push),
    .wr_addr (wr_ptr[PTR_W-1:0]),
    .wr_data (wr_entry),
    .rd_addr (rd_ptr[PTR_W-1:0]),
    .rd_data (head)
  );

  assign DecInstruction = head.instr;
  assign DecPCPlus4     = head.pc_plus4;

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  logic        Clk;
  logic        Reset_n;
  logic [31:0] PCResult;
  logic [31:0] Instruction;
  logic        Flush;
  logic        PCEn;
  logic        DecValid;
  logic [31:0] DecInstruction;
  logic [31:0] DecPCPlus4;
  logic        DecReady;
  logic [1:0]  Count;

  int checks   = 0;
  int failures = 0;

  fetch_queue #(.DEPTH(2)) dut (
    .Clk            (Clk),
    .Reset_n        (Reset_n),
    .PCResult       (PCResult),
    .Instruction    (Instruction),
    .Flush          (Flush),
    .PCEn           (PCEn),
    .DecValid       (DecValid),
    .DecInstruction (DecInstruction),
    .DecPCPlus4     (DecPCPlus4),
    .DecReady       (DecReady),
    .Count          (Count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Advance to just past the next rising edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_head(input string tag, input logic [31:0] instr,
                            input logic [31:0] pc4);
    check({tag, "_valid"}, 32'(DecValid), 32'd1);
    check({tag, "_instr"}, DecInstruction, instr);
    check({tag, "_pc4"}, DecPCPlus4, pc4);
  endtask

  // Wrap sequence: fetch addresses cross 0xFFFFFFFC -> 0x0.
  logic [31:0] wrap_pc  [6] = '{32'hFFFF_FFF0, 32'hFFFF_FFF4, 32'hFFFF_FFF8,
                                32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
  logic        w_ready  [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  int          w_drv    [8] = '{0, 1, 2, 3, 4, 4, 5, 5};
  logic        w_pcen   [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic        w_valid  [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [31:0] w_hinstr [8] = '{32'h0, 32'h1000_0000, 32'h1000_0001, 32'h1000_0001,
                                32'h1000_0002, 32'h1000_0002, 32'h1000_0003,
                                32'h1000_0003};
  logic [31:0] w_hpc4   [8] = '{32'h0, 32'hFFFF_FFF4, 32'hFFFF_FFF8, 32'hFFFF_FFF8,
                                32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000,
                                32'h0000_0000};
  logic [1:0]  w_count  [8] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2};

  initial begin
    // Reset with arbitrary inputs.
    Reset_n     = 1'b0;
    PCResult    = $urandom;
    Instruction = $urandom;
    Flush       = 1'($urandom);
    DecReady    = 1'($urandom);
    #12;
    check("rst_count", 32'(Count), 32'd0);
    check("rst_valid", 32'(DecValid), 32'd0);
    check("rst_instr", DecInstruction, 32'h0);
    check("rst_pc4", DecPCPlus4, 32'h0);
    check("rst_pcen", 32'(PCEn), 32'd1);

    // Release between edges; first fetch at PC 0x0.
    PCResult    = 32'h0;
    Instruction = 32'h2008_0005;
    Flush       = 1'b0;
    DecReady    = 1'b0;
    Reset_n     = 1'b1;
    tick();
    check_head("first", 32'h2008_0005, 32'h4);
    check("first_count", 32'(Count), 32'd1);

    // Fill: second fetch at 0x4 makes the queue full.
    PCResult    = 32'h4;
    Instruction = 32'h8C09_0000;
    tick();
    check("fill_count", 32'(Count), 32'd2);
    PCResult    = 32'h8;
    Instruction = 32'h0109_5020;
    #1;
    check("fill_pcen", 32'(PCEn), 32'd0);

    // Stall: head and count must hold for 5 cycles.
    for (int i = 0; i < 5; i++) begin
      tick();
      check_head("stall", 32'h2008_0005, 32'h4);
      check("stall_count", 32'(Count), 32'd2);
      check("stall_pcen", 32'(PCEn), 32'd0);
    end

    // Full pass-through: decode consumes while fetch of 0x8 proceeds.
    DecReady = 1'b1;
    #1;
    check("pass_pcen", 32'(PCEn), 32'd1);
    tick();
    check("pass_count", 32'(Count), 32'd2);
    check_head("pass", 32'h8C09_0000, 32'h8);

    // Flush while full and decode ready.
    Flush       = 1'b1;
    PCResult    = 32'h100;
    Instruction = 32'hDEAD_BEEF;
    #1;
    check("flush_pcen", 32'(PCEn), 32'd1);
    tick();
    Flush = 1'b0;
    check("flush_count", 32'(Count), 32'd0);
    check("flush_valid", 32'(DecValid), 32'd0);
    PCResult    = 32'h40;
    Instruction = 32'hAAAA_0001;
    DecReady    = 1'b0;
    tick();
    check_head("redirect", 32'hAAAA_0001, 32'h44);
    check("redirect_count", 32'(Count), 32'd1);

    // Empty again before the wrap run.
    Flush = 1'b1;
    tick();
    Flush = 1'b0;
    check("flush2_count", 32'(Count), 32'd0);

    // Wrap: alternating DecReady, PC held when PCEn is low.
    for (int s = 0; s < 8; s++) begin
      DecReady    = w_ready[s];
      PCResult    = wrap_pc[w_drv[s]];
      Instruction = 32'h1000_0000 + 32'(w_drv[s]);
      #1;
      check("wrap_pcen", 32'(PCEn), 32'(w_pcen[s]));
      check("wrap_valid", 32'(DecValid), 32'(w_valid[s]));
      if (w_valid[s]) begin
        check("wrap_instr", DecInstruction, w_hinstr[s]);
        check("wrap_pc4", DecPCPlus4, w_hpc4[s]);
      end
      tick();
      check("wrap_count", 32'(Count), 32'(w_count[s]));
    end
    DecReady = 1'b0;
    check_head("wrap_end", 32'h1000_0004, 32'h0000_0004);

    // Asynchronous reset between edges with the queue full.
    #3;
    Reset_n = 1'b0;
    #1;
    check("areset_valid", 32'(DecValid), 32'd0);
    check("areset_count", 32'(Count), 32'd0);
    check("areset_instr", DecInstruction, 32'h0);
    check("areset_pcen", 32'(PCEn), 32'd1);
    #10;
    Reset_n = 1'b1;
    #5;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
